// File: rtl/axi4_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regs
//
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// The AW and W channels are captured independently into holding registers.
// A write commits on the first edge at which both are held.
// The read channel is a single-beat responder that runs independently of
// the write path.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   S_AXI_AW*         write address channel (AWADDR, AWVALID, AWREADY)
//   S_AXI_W*          write data channel (WDATA, WSTRB, WVALID, WREADY)
//   S_AXI_B*          write response channel (BRESP, BVALID, BREADY)
//   S_AXI_AR*         read address channel (ARADDR, ARVALID, ARREADY)
//   S_AXI_R*          read data channel (RDATA, RRESP, RVALID, RREADY)
//   regs_flat         all register contents, reg i at [32*i+31:32*i]
//   wr_pulse          one-cycle strobe per register, high the cycle after the
//                     new value of that register first becomes visible
// ---------------------------------------------------------------------------
module axi4_lite_slave_regs #(
    parameter int NUM_REGS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [31:0]              S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int          IDX_W      = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [31:0]         regs [NUM_REGS];

    logic                aw_held;
    logic                w_held;
    logic [IDX_W-1:0]    aw_idx;
    logic                aw_ok;
    logic [31:0]         w_data;
    logic [3:0]          w_strb;
    logic [NUM_REGS-1:0] wr_pend;

    logic                aw_fire;
    logic                w_fire;
    logic                ar_fire;
    logic                commit;

    // Comparing the full address against the byte limit also covers the
    // ignored low two bits, because the limit is a multiple of four.
    function automatic logic addr_ok(input logic [31:0] addr);
        return addr < ADDR_LIMIT;
    endfunction

    // Readies depend only on local state and reset, never on the master's
    // readies, so the channels cannot form a combinational loop.
    assign S_AXI_AWREADY = !aw_held && !S_AXI_BVALID && !rst;
    assign S_AXI_WREADY  = !w_held  && !S_AXI_BVALID && !rst;
    assign S_AXI_ARREADY = !S_AXI_RVALID && !rst;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit  = aw_held && w_held;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_flat[32*i +: 32] = regs[i];
    end

    // Write path. The address and data are captured into holding registers.
    // The commit happens one edge later, even when both arrive together.
    // The strobe goes through wr_pend so that it shows up one cycle after the
    // written value becomes visible on regs_flat.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            aw_ok        <= 1'b0;
            w_data       <= '0;
            w_strb       <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            wr_pend      <= '0;
            wr_pulse     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= wr_pend;
            wr_pend  <= '0;

            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[IDX_W+1:2];
                aw_ok   <= addr_ok(S_AXI_AWADDR);
            end

            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end

            // BVALID is always low while both holding flags are set, so a
            // commit and a B handshake never happen at the same edge.
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                if (aw_ok) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b]) begin
                            regs[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                        end
                    end
                    wr_pend <= NUM_REGS'(1) << aw_idx;
                end
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read path. The register array is sampled at the AR handshake edge.
    // A write committing at the same edge is therefore not yet visible, so
    // the read returns the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_fire) begin
            S_AXI_RVALID <= 1'b1;
            if (addr_ok(S_AXI_ARADDR)) begin
                S_AXI_RDATA <= regs[S_AXI_ARADDR[IDX_W+1:2]];
                S_AXI_RRESP <= RESP_OKAY;
            end else begin
                S_AXI_RDATA <= '0;
                S_AXI_RRESP <= RESP_SLVERR;
            end
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave_regs
//
// Directed, self-checking bench for axi4_lite_slave_regs with NUM_REGS = 8.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// sampled at that same point. "Cycle N" is therefore the interval that
// begins at a rising edge.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave_regs;

    localparam int NUM_REGS = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            S_AXI_AWADDR;
    logic                   S_AXI_AWVALID;
    logic                   S_AXI_AWREADY;
    logic [31:0]            S_AXI_WDATA;
    logic [3:0]             S_AXI_WSTRB;
    logic                   S_AXI_WVALID;
    logic                   S_AXI_WREADY;
    logic [1:0]             S_AXI_BRESP;
    logic                   S_AXI_BVALID;
    logic                   S_AXI_BREADY;
    logic [31:0]            S_AXI_ARADDR;
    logic                   S_AXI_ARVALID;
    logic                   S_AXI_ARREADY;
    logic [31:0]            S_AXI_RDATA;
    logic [1:0]             S_AXI_RRESP;
    logic                   S_AXI_RVALID;
    logic                   S_AXI_RREADY;
    logic [NUM_REGS*32-1:0] regs_flat;
    logic [NUM_REGS-1:0]    wr_pulse;

    int pass_count  = 0;
    int check_count = 0;

    axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS)) dut (
        .clk          (clk),
        .rst          (rst),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .S_AXI_ARADDR (S_AXI_ARADDR),
        .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA  (S_AXI_RDATA),
        .S_AXI_RRESP  (S_AXI_RRESP),
        .S_AXI_RVALID (S_AXI_RVALID),
        .S_AXI_RREADY (S_AXI_RREADY),
        .regs_flat    (regs_flat),
        .wr_pulse     (wr_pulse)
    );

    always #5 clk = ~clk;

    // A hard time limit, so that a wedged run still reports and ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    function automatic logic [31:0] reg_val(input int i);
        return regs_flat[32*i +: 32];
    endfunction

    task automatic apply_stimulus(input logic aw_v, input logic [31:0] aw_a,
                                  input logic w_v, input logic [31:0] w_d,
                                  input logic [3:0] w_s);
        S_AXI_AWVALID = aw_v;
        S_AXI_AWADDR  = aw_a;
        S_AXI_WVALID  = w_v;
        S_AXI_WDATA   = w_d;
        S_AXI_WSTRB   = w_s;
    endtask

    // A full write with BREADY high. It returns with BVALID already cleared.
    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        apply_stimulus(1'b1, addr, 1'b1, data, strb);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        S_AXI_ARVALID = 1'b0;
        S_AXI_ARADDR  = 32'h0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

        // Reset state.
        tick();
        tick();
        check_output("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check_output("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check_output("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check_output("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check_output("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check_output("rst_wr_pulse", 32'(wr_pulse),     32'd0);
        check_output("rst_reg0",    reg_val(0),         32'h0);

        rst = 1'b0;
        tick();
        check_output("rel_awready", 32'(S_AXI_AWREADY), 32'd1);
        check_output("rel_wready",  32'(S_AXI_WREADY),  32'd1);
        check_output("rel_arready", 32'(S_AXI_ARREADY), 32'd1);

        // Simultaneous AW/W to 0x04: BVALID and data at N+2, pulse at N+3.
        apply_stimulus(1'b1, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        check_output("sim_bvalid_n1", 32'(S_AXI_BVALID), 32'd0);
        tick();
        check_output("sim_bvalid_n2", 32'(S_AXI_BVALID), 32'd1);
        check_output("sim_bresp",     32'(S_AXI_BRESP),  32'd0);
        check_output("sim_reg1",      reg_val(1),        32'hDEADBEEF);
        check_output("sim_pulse_n2",  32'(wr_pulse),     32'd0);
        check_output("sim_awready_b", 32'(S_AXI_AWREADY), 32'd0);
        tick();
        check_output("sim_pulse_n3",  32'(wr_pulse),     32'b0000_0010);
        check_output("sim_bvalid_n3", 32'(S_AXI_BVALID), 32'd0);
        tick();
        check_output("sim_pulse_n4",  32'(wr_pulse),     32'd0);

        // W three cycles ahead of AW, partial strobes onto 0xAABBCCDD.
        write_reg(32'h08, 32'hAABBCCDD, 4'hF);
        check_output("early_pre", reg_val(2), 32'hAABBCCDD);
        apply_stimulus(1'b0, 32'h0, 1'b1, 32'h11223344, 4'b0101);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        check_output("early_wready",  32'(S_AXI_WREADY),  32'd0);
        check_output("early_awready", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        tick();
        apply_stimulus(1'b1, 32'h08, 1'b0, 32'h0, 4'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        check_output("early_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check_output("early_bresp",  32'(S_AXI_BRESP),  32'd0);
        check_output("early_reg2",   reg_val(2),        32'hAA22CC44);
        tick();

        // Zero strobe to a valid address: OKAY, unchanged data, pulse anyway.
        apply_stimulus(1'b1, 32'h0C, 1'b1, 32'h12345678, 4'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        check_output("zstrb_bresp", 32'(S_AXI_BRESP), 32'd0);
        check_output("zstrb_reg3",  reg_val(3),       32'h0);
        tick();
        check_output("zstrb_pulse", 32'(wr_pulse),    32'b0000_1000);
        tick();

        // Out-of-range write and read at 0x20.
        apply_stimulus(1'b1, 32'h20, 1'b1, 32'hFFFFFFFF, 4'hF);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        check_output("bad_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check_output("bad_bresp",  32'(S_AXI_BRESP),  32'b10);
        check_output("bad_reg0",   reg_val(0),        32'h0);
        check_output("bad_reg1",   reg_val(1),        32'hDEADBEEF);
        check_output("bad_reg7",   reg_val(7),        32'h0);
        tick();
        check_output("bad_pulse",  32'(wr_pulse),     32'd0);
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = 32'h20;
        tick();
        S_AXI_ARVALID = 1'b0;
        check_output("bad_rvalid", 32'(S_AXI_RVALID), 32'd1);
        check_output("bad_rdata",  S_AXI_RDATA,       32'h0);
        check_output("bad_rresp",  32'(S_AXI_RRESP),  32'b10);
        tick();

        // B backpressure for five cycles while a second AW/W waits.
        S_AXI_BREADY = 1'b0;
        apply_stimulus(1'b1, 32'h10, 1'b1, 32'h00000055, 4'hF);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        apply_stimulus(1'b1, 32'h14, 1'b1, 32'h00000066, 4'hF);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_bvalid",  32'(S_AXI_BVALID),  32'd1);
            check_output("bp_bresp",   32'(S_AXI_BRESP),   32'd0);
            check_output("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
            check_output("bp_wready",  32'(S_AXI_WREADY),  32'd0);
            tick();
        end
        S_AXI_BREADY = 1'b1;
        check_output("bp_hs_awready", 32'(S_AXI_AWREADY), 32'd0);
        tick();
        check_output("bp_after_bvalid",  32'(S_AXI_BVALID),  32'd0);
        check_output("bp_after_awready", 32'(S_AXI_AWREADY), 32'd1);
        check_output("bp_after_wready",  32'(S_AXI_WREADY),  32'd1);
        check_output("bp_reg4",          reg_val(4),         32'h55);
        check_output("bp_reg5_pre",      reg_val(5),         32'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        check_output("bp_second_awready", 32'(S_AXI_AWREADY), 32'd0);
        tick();
        check_output("bp_second_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check_output("bp_reg5",          reg_val(5),        32'h66);
        tick();

        // Low address bits are ignored: 0x06 decodes to register 1.
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = 32'h06;
        tick();
        S_AXI_ARVALID = 1'b0;
        check_output("rd6_rdata", S_AXI_RDATA,      32'hDEADBEEF);
        check_output("rd6_rresp", 32'(S_AXI_RRESP), 32'd0);
        tick();

        // Read of 0x0C held for three cycles with RREADY low.
        write_reg(32'h0C, 32'hCAFEF00D, 4'hF);
        S_AXI_RREADY  = 1'b0;
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = 32'h0C;
        check_output("rdhold_arready0", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("rdhold_rvalid",  32'(S_AXI_RVALID),  32'd1);
            check_output("rdhold_rdata",   S_AXI_RDATA,        32'hCAFEF00D);
            check_output("rdhold_arready", 32'(S_AXI_ARREADY), 32'd0);
            tick();
        end
        S_AXI_RREADY = 1'b1;
        tick();
        check_output("rdhold_done_rvalid",  32'(S_AXI_RVALID),  32'd0);
        check_output("rdhold_done_arready", 32'(S_AXI_ARREADY), 32'd1);

        // A read sampled at the write's commit edge sees the old value.
        apply_stimulus(1'b1, 32'h04, 1'b1, 32'h0BADCAFE, 4'hF);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        S_AXI_ARVALID = 1'b1;
        S_AXI_ARADDR  = 32'h04;
        tick();
        S_AXI_ARVALID = 1'b0;
        check_output("rw_rdata_old", S_AXI_RDATA,       32'hDEADBEEF);
        check_output("rw_reg1_new",  reg_val(1),        32'h0BADCAFE);
        check_output("rw_bvalid",    32'(S_AXI_BVALID), 32'd1);
        tick();

        // Reset between AW and W discards the held address.
        apply_stimulus(1'b1, 32'h04, 1'b0, 32'h0, 4'h0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        rst = 1'b1;
        tick();
        check_output("mid_rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check_output("mid_rst_wready",  32'(S_AXI_WREADY),  32'd0);
        check_output("mid_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check_output("mid_rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        rst = 1'b0;
        tick();
        check_output("mid_rel_awready", 32'(S_AXI_AWREADY), 32'd1);
        check_output("mid_rel_wready",  32'(S_AXI_WREADY),  32'd1);
        check_output("mid_rel_arready", 32'(S_AXI_ARREADY), 32'd1);
        for (int i = 0; i < NUM_REGS; i++) begin
            check_output("mid_rel_reg", reg_val(i), 32'h0);
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 32'h77777777, 4'hF);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        check_output("mid_w_only_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check_output("mid_w_only_reg1",   reg_val(1),        32'h0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
AXI4_LITE_SLAVE_REGS -- requirements
Module: axi4_lite_slave_regs

Interface
REQ-001 Parameter NUM_REGS, default 8, number of 32-bit registers (power of two, 2..16).
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 S_AXI_AWADDR  input  32  write address; S_AXI_AWVALID input 1; S_AXI_AWREADY output 1.
REQ-005 S_AXI_WDATA  input  32  write data; S_AXI_WSTRB input 4 byte enables; S_AXI_WVALID input 1; S_AXI_WREADY output 1.
REQ-006 S_AXI_BRESP  output  2  write response; S_AXI_BVALID output 1; S_AXI_BREADY input 1.
REQ-007 S_AXI_ARADDR  input  32  read address; S_AXI_ARVALID input 1; S_AXI_ARREADY output 1.
REQ-008 S_AXI_RDATA  output  32  read data; S_AXI_RRESP output 2; S_AXI_RVALID output 1; S_AXI_RREADY input 1.
REQ-009 regs_flat  output  NUM_REGS*32  current register contents, reg i at bits [32*i+31:32*i].
REQ-010 wr_pulse  output  NUM_REGS  one-cycle strobe, bit i high in the cycle after reg i is written.

Function
REQ-011 Decode: index = ADDR[log2(NUM_REGS)+1:2]; address valid iff ADDR < NUM_REGS*4; ADDR[1:0] ignored.
REQ-012 Write channel: AW and W SHALL be accepted independently, in either order or same cycle, into internal holding flags aw_held / w_held.
REQ-013 S_AXI_AWREADY = !aw_held && !S_AXI_BVALID && !rst; S_AXI_WREADY = !w_held && !S_AXI_BVALID && !rst.
REQ-014 In a cycle where aw_held && w_held: at that edge, update bytes of reg[index] whose WSTRB bit is 1, clear both flags, set BVALID=1, set wr_pulse[index]=1 for the next cycle.
REQ-015 Write latency: later of AW/W handshake in cycle N -> register value and BVALID visible in cycle N+2.
REQ-016 Valid address -> BRESP=2'b00 (OKAY); invalid address -> BRESP=2'b10 (SLVERR), no register change, wr_pulse all zero.
REQ-017 WSTRB=4'b0000 to valid address -> OKAY, no byte changed, wr_pulse still asserted.
REQ-018 BVALID and BRESP SHALL hold stable until BVALID && BREADY; BVALID clears at that edge; no new AW/W accepted while BVALID=1.
REQ-019 Read channel: S_AXI_ARREADY = !S_AXI_RVALID && !rst.
REQ-020 AR handshake in cycle N -> RVALID=1, RDATA=reg[index] (or 32'h0 with RRESP=2'b10 if invalid), RRESP=2'b00 if valid, visible cycle N+1.
REQ-021 RVALID, RDATA, RRESP SHALL hold stable until RVALID && RREADY; RVALID clears at that edge; back-to-back reads therefore cost 2 cycles minimum each.
REQ-022 Read and write channels SHALL be fully independent; read sampling reg i at the same edge reg i is written returns the pre-write value.
REQ-023 Output valids SHALL never depend combinationally on input readies; readies may not drop once asserted except after their own handshake or reset.

Reset
REQ-024 While rst=1 at a rising edge: all registers 32'h0, aw_held=w_held=0, BVALID=0, RVALID=0, BRESP=RRESP=2'b00, RDATA=32'h0, wr_pulse=0.
REQ-025 While rst=1, AWREADY, WREADY, ARREADY SHALL be 0; reset mid-transaction discards held AW/W and pending responses without writing.
REQ-026 First cycle after rst deasserts: AWREADY=WREADY=ARREADY=1.

Verification
REQ-027 Simultaneous AW=0x04, W=0xDEADBEEF, WSTRB=4'hF, BREADY=1 in cycle N -> BVALID=1, BRESP=00, regs_flat[63:32]=0xDEADBEEF in cycle N+2, wr_pulse=8'b0000_0010 in cycle N+3.
REQ-028 W (0x11223344, WSTRB=4'b0101) three cycles before AW=0x08 on reg holding 0xAABBCCDD -> reg2=0xAA22CC44, BRESP=00.
REQ-029 Write to 0x20 with NUM_REGS=8 -> BRESP=10, regs_flat unchanged, wr_pulse=0; read 0x20 -> RDATA=0, RRESP=10.
REQ-030 BREADY held 0 for 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout, second AW stalls until B handshake.
REQ-031 Read 0x0C with RREADY=0 for 3 cycles -> RVALID and RDATA stable, ARREADY=0 until handshake; then ARREADY=1 next cycle.
REQ-032 rst asserted in the cycle after AW handshake (before W) -> no write occurs, BVALID never rises, all regs 0, readies 1 after reset release.
